// File: rtl/im_uart_loader.sv
// UART program loader: receives a sync/length/payload/checksum frame and writes
// 32-bit words into instruction memory while holding the CPU pipeline.
module im_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    L_IDLE, L_LEN_HI, L_LEN_LO, L_DATA, L_WR, L_CSUM, L_DONE, L_ERR
  } ld_state_t;

  rx_state_t        rx_state, rx_next;
  ld_state_t        state, state_next;
  logic             rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_shift, rx_byte;
  logic             byte_valid, frame_err;
  logic [7:0]       len_hi, csum;
  logic [ADDR_W:0]  n_words;
  logic [23:0]      asm_word;
  logic [1:0]       byte_cnt;
  logic [15:0]      len_words;

  assign rx_byte   = rx_shift;
  assign len_words = {len_hi, rx_byte};

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
      RX_START: if (cnt == CNT_HALF) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt == CNT_FULL && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (cnt == CNT_FULL) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      rx_state   <= rx_next;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (rx_state == RX_IDLE || rx_next != rx_state ||
          (rx_state == RX_DATA && cnt == CNT_FULL))
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
      if (rx_state == RX_IDLE) bit_idx <= '0;
      if (rx_state == RX_DATA && cnt == CNT_FULL) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        bit_idx  <= bit_idx + 3'd1;
      end
      // Stop bit sampled at its centre decides between a good byte and a framing error
      if (rx_state == RX_STOP && cnt == CNT_FULL) begin
        byte_valid <= rx_sync;
        frame_err  <= !rx_sync;
      end
    end
  end

  always_comb begin
    state_next = state;
    if (frame_err && !(state inside {L_IDLE, L_DONE, L_ERR})) begin
      state_next = L_ERR;
    end else begin
      case (state)
        L_IDLE, L_DONE, L_ERR:
          if (byte_valid && rx_byte == 8'hA5) state_next = L_LEN_HI;
        L_LEN_HI: if (byte_valid) state_next = L_LEN_LO;
        L_LEN_LO:
          if (byte_valid)
            state_next = (len_words == 16'd0 || {1'b0, len_words} > MAX_WORDS)
                         ? L_ERR : L_DATA;
        L_DATA: if (byte_valid && byte_cnt == 2'd3) state_next = L_WR;
        L_WR:
          state_next = (word_count + (ADDR_W+1)'(1) == n_words) ? L_CSUM : L_DATA;
        L_CSUM:
          if (byte_valid) state_next = (rx_byte == csum) ? L_DONE : L_ERR;
        default: state_next = L_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= L_IDLE;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      word_count <= '0;
      len_hi     <= '0;
      n_words    <= '0;
      csum       <= '0;
      asm_word   <= '0;
      byte_cnt   <= '0;
    end else begin
      state <= state_next;
      im_we <= 1'b0;
      case (state)
        L_IDLE, L_DONE, L_ERR:
          if (byte_valid && rx_byte == 8'hA5) begin
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            word_count <= '0;
            im_addr    <= '0;
            csum       <= '0;
            byte_cnt   <= '0;
          end
        L_LEN_HI: if (byte_valid) len_hi <= rx_byte;
        L_LEN_LO: if (byte_valid) n_words <= len_words[ADDR_W:0];
        L_DATA:
          if (byte_valid) begin
            asm_word <= {asm_word[15:0], rx_byte};
            csum     <= csum ^ rx_byte;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              im_we    <= 1'b1;
              im_wdata <= {asm_word, rx_byte};
              im_addr  <= word_count[ADDR_W-1:0];
            end
          end
        L_WR: word_count <= word_count + (ADDR_W+1)'(1);
        default: ;
      endcase
      if (state_next == L_ERR && state != L_ERR) begin
        load_err <= 1'b1;
        cpu_hold <= 1'b1;
      end
      if (state_next == L_DONE && state != L_DONE) begin
        load_done <= 1'b1;
        cpu_hold  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_im_uart_loader.sv
// Bench for im_uart_loader: drives UART frames and scoreboards IM writes.
module tb_im_uart_loader;

  localparam int CPB = 16;
  localparam int AW  = 10;
  localparam logic [31:0] W0 = 32'h20080005;
  localparam logic [31:0] W1 = 32'h2009000A;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx  = 1'b1;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_hold, load_done, load_err;
  logic [AW:0]   word_count;

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;
  logic we_prev = 1'b0;
  logic [AW+31:0] exp_q[$];

  im_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rx(rx), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_err(load_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Scoreboard side: every IM write must match the next expected {addr,data}
  always @(negedge clk) begin
    if (rst && im_we) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got addr=%0d data=%h exp=no write", im_addr, im_wdata);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        if ({im_addr, im_wdata} !== e) begin
          failures++;
          $display("FAIL write got addr=%0d data=%h exp addr=%0d data=%h",
                   im_addr, im_wdata, e[AW+31:32], e[31:0]);
        end
      end
      checks++;
      if (we_prev) begin
        failures++;
        $display("FAIL we_double got=two-cycle pulse exp=single-cycle pulse");
      end
    end
    we_prev = rst ? im_we : 1'b0;
  end

  function automatic logic [7:0] xor_bytes(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    drive_bit(1'b1);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [AW-1:0] a);
    exp_q.push_back({a, w});
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], 1'b1);
  endtask

  task automatic send_std_frame(input logic [7:0] cs);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_word(W0, '0);
    send_word(W1, AW'(1));
    send_byte(cs, 1'b1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (4) @(posedge clk);
    #1;
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL rst_hold got=%b exp=1", cpu_hold); end
    checks++; if (im_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", im_we); end
    checks++; if (load_done !== 1'b0 || load_err !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", load_done, load_err); end
    checks++; if (word_count !== '0 || im_addr !== '0 || im_wdata !== '0) begin failures++; $display("FAIL rst_regs got=%0d/%0d/%h exp=0/0/0", word_count, im_addr, im_wdata); end
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    checks++; if (cpu_hold !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin failures++; $display("FAIL noise_flags got=%b%b%b exp=100", cpu_hold, load_done, load_err); end
    checks++; if (wr_count !== 0 || word_count !== '0) begin failures++; $display("FAIL noise_writes got=%0d/%0d exp=0/0", wr_count, word_count); end
  endtask

  task automatic test_good_load();
    int w0;
    w0 = wr_count;
    send_std_frame(xor_bytes(W0) ^ xor_bytes(W1));
    checks++; if (wr_count - w0 !== 2 || exp_q.size() !== 0) begin failures++; $display("FAIL good_writes got=%0d pending=%0d exp=2/0", wr_count - w0, exp_q.size()); end
    checks++; if (word_count !== (AW+1)'(2)) begin failures++; $display("FAIL good_count got=%0d exp=2", word_count); end
    checks++; if (load_done !== 1'b1 || cpu_hold !== 1'b0 || load_err !== 1'b0) begin failures++; $display("FAIL good_flags got done=%b hold=%b err=%b exp=1/0/0", load_done, cpu_hold, load_err); end
  endtask

  task automatic test_bad_csum();
    int w0;
    w0 = wr_count;
    send_std_frame(8'h07);
    checks++; if (wr_count - w0 !== 2 || exp_q.size() !== 0) begin failures++; $display("FAIL badcs_writes got=%0d pending=%0d exp=2/0", wr_count - w0, exp_q.size()); end
    checks++; if (load_err !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0) begin failures++; $display("FAIL badcs_flags got err=%b hold=%b done=%b exp=1/1/0", load_err, cpu_hold, load_done); end
  endtask

  task automatic test_len_errors();
    int w0;
    w0 = wr_count;
    send_byte(8'hA5, 1'b1);
    checks++; if (load_err !== 1'b0 || cpu_hold !== 1'b1) begin failures++; $display("FAIL sync_clear got err=%b hold=%b exp=0/1", load_err, cpu_hold); end
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    checks++; if (load_err !== 1'b1 || wr_count !== w0) begin failures++; $display("FAIL len0 got err=%b writes=%0d exp=1/0", load_err, wr_count - w0); end
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h01, 1'b1);
    checks++; if (load_err !== 1'b1 || wr_count !== w0 || word_count !== '0) begin failures++; $display("FAIL len1025 got err=%b writes=%0d cnt=%0d exp=1/0/0", load_err, wr_count - w0, word_count); end
  endtask

  task automatic test_framing();
    int w0;
    w0 = wr_count;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h08, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (load_err !== 1'b1 || cpu_hold !== 1'b1) begin failures++; $display("FAIL frame_err got err=%b hold=%b exp=1/1", load_err, cpu_hold); end
    checks++; if (wr_count !== w0 || word_count !== '0) begin failures++; $display("FAIL frame_nowrite got writes=%0d cnt=%0d exp=0/0", wr_count - w0, word_count); end
    send_std_frame(xor_bytes(W0) ^ xor_bytes(W1));
    checks++; if (load_done !== 1'b1 || load_err !== 1'b0 || cpu_hold !== 1'b0 || wr_count - w0 !== 2) begin failures++; $display("FAIL frame_recover got done=%b err=%b hold=%b writes=%0d exp=1/0/0/2", load_done, load_err, cpu_hold, wr_count - w0); end
  endtask

  task automatic test_reset_mid_load();
    int w0;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h00, 1'b1);
    checks++; if (load_err !== 1'b0 || cpu_hold !== 1'b1) begin failures++; $display("FAIL len1024 got err=%b hold=%b exp=0/1", load_err, cpu_hold); end
    send_word(32'h11223344, '0);
    send_byte(8'h55, 1'b1);
    checks++; if (word_count !== (AW+1)'(1) || exp_q.size() !== 0) begin failures++; $display("FAIL mid_count got=%0d pending=%0d exp=1/0", word_count, exp_q.size()); end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++; if (cpu_hold !== 1'b1 || im_we !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0) begin failures++; $display("FAIL midrst_flags got hold=%b we=%b done=%b err=%b exp=1/0/0/0", cpu_hold, im_we, load_done, load_err); end
    checks++; if (word_count !== '0 || im_addr !== '0 || im_wdata !== '0) begin failures++; $display("FAIL midrst_regs got=%0d/%0d/%h exp=0/0/0", word_count, im_addr, im_wdata); end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    w0 = wr_count;
    send_std_frame(xor_bytes(W0) ^ xor_bytes(W1));
    checks++; if (load_done !== 1'b1 || cpu_hold !== 1'b0 || word_count !== (AW+1)'(2) || wr_count - w0 !== 2) begin failures++; $display("FAIL midrst_reload got done=%b hold=%b cnt=%0d writes=%0d exp=1/0/2/2", load_done, cpu_hold, word_count, wr_count - w0); end
  endtask

  task automatic test_reload_hold();
    logic [7:0] b;
    b = 8'hA5;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    rx = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL reload_early got hold=%b exp=0", cpu_hold); end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (cpu_hold !== 1'b1 || load_done !== 1'b0) begin failures++; $display("FAIL reload_hold got hold=%b done=%b exp=1/0", cpu_hold, load_done); end
    repeat (CPB) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_csum();
    test_len_errors();
    test_framing();
    test_reset_mid_load();
    test_reload_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
